lsam_error_monitor: RTL and testbench
=====================================

Name: lsam_error_monitor

Overview:
- Sits directly downstream of the 8x8 LSAM approximate multiplier and consumes its operands and approximate product.
- For each accepted sample it computes the exact product internally and derives the absolute error.
- Accumulates error statistics over a fixed window of samples, then presents one result record through a valid/ready handshake.
- Provides on-silicon and in-simulation accuracy characterisation of the approximate multiplier without software post-processing.

Parameters:
- WIN_LOG2, 8, window length is 2^WIN_LOG2 samples (legal 1..12).
- ACC_W, 24, width of the saturating sum-of-absolute-error accumulator (legal 16..32).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  sample present on a/b/p_approx
- in_ready  output  1  block can accept a sample this cycle
- a  input  8  multiplier operand A (unsigned)
- b  input  8  multiplier operand B (unsigned)
- p_approx  input  16  approximate product from the multiplier for a, b
- flush  input  1  close the current window early
- res_valid  output  1  result record valid
- res_ready  input  1  consumer accepts result record
- res_sum_err  output  ACC_W  sum of |p_approx - a*b| over window, saturating
- res_max_err  output  16  maximum |p_approx - a*b| in window
- res_mismatch  output  WIN_LOG2+1  number of samples with nonzero error
- res_count  output  WIN_LOG2+1  number of samples in the window

Behaviour:
- Reset: all outputs and internal registers are 0 except in_ready, which is 1. State is COLLECT. Reset is honoured mid-window and mid-HOLD; partial statistics are discarded.
- States: COLLECT (in_ready=1, res_valid=0) and HOLD (in_ready=0, res_valid=1).
- Accept: a sample is accepted when in_valid && in_ready.
- Error computation, per accepted sample:
  - exact = a*b, 16-bit unsigned.
  - diff = p_approx - exact, 17-bit signed.
  - err = |diff|, which always fits 16 bits.
- Accumulator updates on accept:
  - sum += err, saturating at 2^ACC_W-1 (it holds there and never wraps).
  - max = max(max, err).
  - mismatch += (err != 0).
  - count += 1.
- Window close: the window closes when the accepted sample brings count to 2^WIN_LOG2, or when flush=1 in COLLECT with count (including any sample accepted that same cycle) >= 1.
  - A sample accepted in the same cycle as flush is included in the record.
  - flush with count 0 and no accept is ignored.
  - flush in HOLD is ignored.
- On close, the next clock edge:
  - latches the updated statistics into the res_* registers,
  - sets res_valid=1 and in_ready=0,
  - enters HOLD.
  - Latency is 1 cycle from the last accepted sample to res_valid.
- HOLD:
  - res_* outputs are stable while res_valid && !res_ready.
  - On res_valid && res_ready, the next edge clears the accumulators and count, drops res_valid, raises in_ready, and returns to COLLECT.
  - res_* data registers keep their last values after the handshake; only res_valid qualifies them.
- No sample is accepted in the cycle res_valid && res_ready occurs, because in_ready is still 0.
- Maximum throughput: 2^WIN_LOG2 samples per 2^WIN_LOG2+1 cycles when res_ready is held at 1.
- in_valid while in_ready=0: the bench/upstream must hold its data; the block never drops or double-counts a sample.

Test Plan:
- Reset and exact window: WIN_LOG2=2; assert rst mid-cycle, then drive 4 samples with p_approx=a*b (0x0, 255x1, 12x15, 128x128), res_ready=1 -> res_valid one cycle after 4th accept; sum=0, max=0, mismatch=0, count=4; all outputs 0 and in_ready=1 during reset.
- Known errors: WIN_LOG2=2; samples (100,200,p=19968), (50,5,p=250), (255,255,p=65535), (12,15,p=176) -> errors 32, 0, 510, 4; sum=546, max=510, mismatch=3, count=4.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid -> res_* stable, in_ready=0, presented samples not counted; on res_ready=1, the next window starts with count=0 and the following window's stats are independent.
- Flush: WIN_LOG2=3; 2 samples with errors 7 and 0, then flush together with a third sample of error 3 -> count=3, sum=10, max=7, mismatch=2; a flush at count 0 produces no res_valid.
- Saturation: ACC_W=16, WIN_LOG2=2; 4 samples of (255,255,p=0), error 65025 each -> sum=65535, max=65025, mismatch=4.
- Reset mid-window: accept 3 of 4 samples, pulse rst asynchronously between edges -> outputs cleared immediately; after reset, 4 fresh exact samples yield count=4, sum=0.

Source files
------------

// File: rtl/lsam_error_monitor.sv
// Accuracy monitor for the 8x8 LSAM approximate multiplier: accumulates |p_approx - a*b|
// statistics over a window of samples and presents one result record via valid/ready.
module lsam_error_monitor #(
    parameter int unsigned WIN_LOG2 = 8,
    parameter int unsigned ACC_W    = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          a,
    input  logic [7:0]          b,
    input  logic [15:0]         p_approx,
    input  logic                flush,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [ACC_W-1:0]    res_sum_err,
    output logic [15:0]         res_max_err,
    output logic [WIN_LOG2:0]   res_mismatch,
    output logic [WIN_LOG2:0]   res_count
);

    localparam int unsigned CW = WIN_LOG2 + 1;
    localparam logic [CW-1:0] WinLen = CW'(1) << WIN_LOG2;

    localparam logic StCollect = 1'b0;
    localparam logic StHold    = 1'b1;

    logic            state_q, state_d;
    logic [ACC_W-1:0] sum_q, sum_d, res_sum_q, res_sum_d;
    logic [15:0]     max_q, max_d, res_max_q, res_max_d;
    logic [CW-1:0]   mis_q, mis_d, res_mis_q, res_mis_d;
    logic [CW-1:0]   cnt_q, cnt_d, res_cnt_q, res_cnt_d;

    logic [15:0]     exact, err;
    logic [ACC_W:0]  sum_wide;
    logic [ACC_W-1:0] sum_upd;
    logic [15:0]     max_upd;
    logic [CW-1:0]   mis_upd, cnt_upd;
    logic            accept, close;

    assign exact = 16'(a) * 16'(b);
    assign err   = (p_approx >= exact) ? (p_approx - exact) : (exact - p_approx);

    // One extra bit catches the carry so the sum can pin at all-ones instead of wrapping.
    assign sum_wide = {1'b0, sum_q} + {{(ACC_W - 15){1'b0}}, err};
    assign sum_upd  = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
    assign max_upd  = (err > max_q) ? err : max_q;
    assign mis_upd  = mis_q + CW'(err != 16'd0);
    assign cnt_upd  = cnt_q + CW'(1);

    assign in_ready  = (state_q == StCollect);
    assign res_valid = (state_q == StHold);
    assign accept    = in_valid && in_ready;
    assign close     = in_ready && ((accept && (cnt_upd == WinLen)) ||
                                    (flush && (accept || (cnt_q != '0))));

    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        max_d     = max_q;
        mis_d     = mis_q;
        cnt_d     = cnt_q;
        res_sum_d = res_sum_q;
        res_max_d = res_max_q;
        res_mis_d = res_mis_q;
        res_cnt_d = res_cnt_q;
        if (state_q == StCollect) begin
            if (accept) begin
                sum_d = sum_upd;
                max_d = max_upd;
                mis_d = mis_upd;
                cnt_d = cnt_upd;
            end
            if (close) begin
                res_sum_d = sum_d;
                res_max_d = max_d;
                res_mis_d = mis_d;
                res_cnt_d = cnt_d;
                state_d   = StHold;
            end
        end else if (res_ready) begin
            sum_d   = '0;
            max_d   = '0;
            mis_d   = '0;
            cnt_d   = '0;
            state_d = StCollect;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StCollect;
            sum_q     <= '0;
            max_q     <= '0;
            mis_q     <= '0;
            cnt_q     <= '0;
            res_sum_q <= '0;
            res_max_q <= '0;
            res_mis_q <= '0;
            res_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            max_q     <= max_d;
            mis_q     <= mis_d;
            cnt_q     <= cnt_d;
            res_sum_q <= res_sum_d;
            res_max_q <= res_max_d;
            res_mis_q <= res_mis_d;
            res_cnt_q <= res_cnt_d;
        end
    end

    assign res_sum_err  = res_sum_q;
    assign res_max_err  = res_max_q;
    assign res_mismatch = res_mis_q;
    assign res_count    = res_cnt_q;

endmodule

// File: tb/tb_lsam_error_monitor.sv
// Directed bench for lsam_error_monitor with a 4-sample window and a 16-bit accumulator.
module tb_lsam_error_monitor;

    localparam int unsigned WIN_LOG2 = 2;
    localparam int unsigned ACC_W    = 16;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [7:0]          a;
    logic [7:0]          b;
    logic [15:0]         p_approx;
    logic                flush;
    logic                res_valid;
    logic                res_ready;
    logic [ACC_W-1:0]    res_sum_err;
    logic [15:0]         res_max_err;
    logic [WIN_LOG2:0]   res_mismatch;
    logic [WIN_LOG2:0]   res_count;

    int checks = 0;
    int errors = 0;

    lsam_error_monitor #(
        .WIN_LOG2 (WIN_LOG2),
        .ACC_W    (ACC_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a            (a),
        .b            (b),
        .p_approx     (p_approx),
        .flush        (flush),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_sum_err  (res_sum_err),
        .res_max_err  (res_max_err),
        .res_mismatch (res_mismatch),
        .res_count    (res_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input int s, input int m, input int mm,
                           input int c);
        chk({tag, "_valid"}, 32'(res_valid), 32'd1);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_sum"}, 32'(res_sum_err), 32'(s));
        chk({tag, "_max"}, 32'(res_max_err), 32'(m));
        chk({tag, "_mismatch"}, 32'(res_mismatch), 32'(mm));
        chk({tag, "_count"}, 32'(res_count), 32'(c));
    endtask

    task automatic put(input logic [7:0] ia, input logic [7:0] ib, input logic [15:0] ip,
                       input logic fl);
        @(negedge clk);
        a        = ia;
        b        = ib;
        p_approx = ip;
        flush    = fl;
        in_valid = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; p_approx = '0;
        flush = 1'b0; res_ready = 1'b0;

        // Asynchronous reset asserted between edges
        #7 rst = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_sum", 32'(res_sum_err), 32'd0);
        chk("rst_max", 32'(res_max_err), 32'd0);
        chk("rst_mismatch", 32'(res_mismatch), 32'd0);
        chk("rst_count", 32'(res_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        res_ready = 1'b1;

        // Exact window
        put(8'd0, 8'd0, 16'd0, 1'b0);
        put(8'd255, 8'd1, 16'd255, 1'b0);
        put(8'd12, 8'd15, 16'd180, 1'b0);
        put(8'd128, 8'd128, 16'd16384, 1'b0);
        chk("exact_valid_early", 32'(res_valid), 32'd0);
        idle();
        chk_res("exact", 0, 0, 0, 4);
        idle();
        chk("exact_drop_valid", 32'(res_valid), 32'd0);
        chk("exact_in_ready", 32'(in_ready), 32'd1);
        res_ready = 1'b0;

        // Known errors 32, 0, 510, 4, then backpressure
        put(8'd100, 8'd200, 16'd19968, 1'b0);
        put(8'd50, 8'd5, 16'd250, 1'b0);
        put(8'd255, 8'd255, 16'd65535, 1'b0);
        put(8'd12, 8'd15, 16'd176, 1'b0);
        idle();
        chk_res("known", 546, 510, 3, 4);
        for (int i = 0; i < 5; i++) begin
            put(8'd255, 8'd255, 16'd0, 1'b0);
            chk_res("hold", 546, 510, 3, 4);
        end
        res_ready = 1'b1;
        idle();
        chk("bp_drop_valid", 32'(res_valid), 32'd0);
        chk("bp_in_ready", 32'(in_ready), 32'd1);
        chk("bp_keep_sum", 32'(res_sum_err), 32'd546);
        put(8'd3, 8'd3, 16'd9, 1'b0);
        put(8'd3, 8'd3, 16'd10, 1'b0);
        put(8'd0, 8'd0, 16'd0, 1'b0);
        put(8'd2, 8'd2, 16'd4, 1'b0);
        chk("next_valid_early", 32'(res_valid), 32'd0);
        idle();
        chk_res("next", 1, 1, 1, 4);
        idle();

        // Flush with a same-cycle sample: errors 7, 0, 3
        put(8'd10, 8'd10, 16'd107, 1'b0);
        put(8'd5, 8'd5, 16'd25, 1'b0);
        put(8'd1, 8'd3, 16'd0, 1'b1);
        idle();
        chk_res("flush", 10, 7, 2, 3);
        idle();
        chk("flush_drop_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        flush = 1'b1;
        idle();
        chk("flush0_valid", 32'(res_valid), 32'd0);
        chk("flush0_in_ready", 32'(in_ready), 32'd1);
        idle();
        chk("flush0_valid2", 32'(res_valid), 32'd0);

        // Saturation: 4 x 65025 into a 16-bit accumulator
        for (int i = 0; i < 4; i++) put(8'd255, 8'd255, 16'd0, 1'b0);
        idle();
        chk_res("sat", 65535, 65025, 4, 4);
        idle();

        // Reset mid-window discards the partial window
        put(8'd2, 8'd3, 16'd6, 1'b0);
        put(8'd4, 8'd4, 16'd16, 1'b0);
        put(8'd9, 8'd9, 16'd81, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_sum", 32'(res_sum_err), 32'd0);
        chk("mid_rst_max", 32'(res_max_err), 32'd0);
        chk("mid_rst_count", 32'(res_count), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        #1 rst = 1'b0;
        put(8'd7, 8'd7, 16'd49, 1'b0);
        put(8'd1, 8'd1, 16'd1, 1'b0);
        put(8'd0, 8'd9, 16'd0, 1'b0);
        put(8'd200, 8'd100, 16'd20000, 1'b0);
        chk("post_rst_valid_early", 32'(res_valid), 32'd0);
        idle();
        chk_res("post_rst", 0, 0, 0, 4);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
